// File: rtl/sad_stream_accum.sv
// Streaming sum-of-absolute-differences engine: accumulates one candidate SAD over
// BEATS words of LANES pixels and tracks the running minimum with its candidate index.
module sad_stream_accum #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int BEATS = 4,
  parameter int SAD_W = 32,
  parameter int IDX_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [LANES*PIX_W-1:0] win_data,
  input  logic [LANES*PIX_W-1:0] frm_data,
  output logic                   sad_valid,
  output logic [SAD_W-1:0]       sad_value,
  output logic [IDX_W-1:0]       sad_idx,
  output logic                   min_valid,
  output logic [SAD_W-1:0]       min_sad,
  output logic [IDX_W-1:0]       min_idx,
  output logic                   busy
);

  localparam int SUM_W = PIX_W + $clog2(LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EXT_W = ((SAD_W > SUM_W) ? SAD_W : SUM_W) + 1;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  // Valid/ready contract: in_valid alone qualifies a beat on each rising edge;
  // there is no ready, so the engine must accept every beat offered.

  logic [SUM_W-1:0] w_lane_sum;
  logic             w_last_beat;
  logic [EXT_W-1:0] w_ext_sum;
  logic [SAD_W-1:0] w_sat_sum;

  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_s1_valid;
  logic             r_s1_last;
  logic [SUM_W-1:0] r_s1_sum;
  logic [SAD_W-1:0] r_acc;
  logic             r_sad_valid;
  logic [SAD_W-1:0] r_sad_value;
  logic [IDX_W-1:0] r_sad_idx;
  logic [IDX_W-1:0] r_cand_idx;
  logic             r_min_valid;
  logic [SAD_W-1:0] r_min_sad;
  logic [IDX_W-1:0] r_min_idx;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_sum = w_lane_sum +
                   SUM_W'(abs_diff(win_data[i*PIX_W +: PIX_W], frm_data[i*PIX_W +: PIX_W]));
    end
  end

  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

  // The accumulator clamps rather than wraps, so a saturated partial sum stays saturated.
  assign w_ext_sum = EXT_W'(r_acc) + EXT_W'(r_s1_sum);
  assign w_sat_sum = (w_ext_sum > EXT_W'(SAD_MAX)) ? SAD_MAX : w_ext_sum[SAD_W-1:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_beat_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sum   <= w_lane_sum;
        r_s1_last  <= w_last_beat;
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc       <= '0;
      r_sad_valid <= 1'b0;
      r_sad_value <= '0;
      r_sad_idx   <= '0;
      r_cand_idx  <= '0;
      r_min_valid <= 1'b0;
      r_min_sad   <= '1;
      r_min_idx   <= '0;
    end else if (clear) begin
      // sad_value/sad_idx deliberately hold so the last reported result stays readable.
      r_acc       <= '0;
      r_sad_valid <= 1'b0;
      r_cand_idx  <= '0;
      r_min_valid <= 1'b0;
      r_min_sad   <= '1;
    end else begin
      r_sad_valid <= 1'b0;
      if (r_s1_valid) begin
        if (r_s1_last) begin
          r_sad_value <= w_sat_sum;
          r_sad_idx   <= r_cand_idx;
          r_sad_valid <= 1'b1;
          r_acc       <= '0;
          r_cand_idx  <= r_cand_idx + IDX_W'(1);
          // Strict less-than keeps the earlier index on ties.
          if (!r_min_valid || (w_sat_sum < r_min_sad)) begin
            r_min_valid <= 1'b1;
            r_min_sad   <= w_sat_sum;
            r_min_idx   <= r_cand_idx;
          end
        end else begin
          r_acc <= w_sat_sum;
        end
      end
    end
  end

  assign sad_valid = r_sad_valid;
  assign sad_value = r_sad_value;
  assign sad_idx   = r_sad_idx;
  assign min_valid = r_min_valid;
  assign min_sad   = r_min_sad;
  assign min_idx   = r_min_idx;
  assign busy      = (r_beat_cnt != '0) | r_s1_valid;

endmodule

// File: doc/sad_stream_accum.md
Name: sad_stream_accum

Overview:
- Parametrised, pipelined sum-of-absolute-differences engine for the motion-estimation datapath.
- Consumes a stream of paired window/frame words, LANES pixels per word, and accumulates one candidate SAD over BEATS words.
- Emits each candidate's SAD with a valid pulse and keeps a running minimum with its candidate index.
- Sits between the SAD memory read port and the control core, replacing fixed 4x4 combinational SAD evaluation.

Parameters:
- PIX_W, 8, bits per pixel (unsigned).
- LANES, 4, pixels per input word.
- BEATS, 4, words per candidate block (block = LANES*BEATS pixels); must be >= 1.
- SAD_W, 32, width of the SAD result and accumulator.
- IDX_W, 8, width of the candidate index counter.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: drops the partial block and in-flight beat, and resets the candidate index and minimum tracker.
- in_valid  in  1  beat qualifier; one beat is accepted on each edge where it is high. There is no backpressure.
- win_data  in  LANES*PIX_W  window pixels; lane i = bits [i*PIX_W +: PIX_W].
- frm_data  in  LANES*PIX_W  frame pixels, same lane packing.
- sad_valid  out  1  one-cycle pulse: sad_value holds a completed candidate.
- sad_value  out  SAD_W  SAD of the last completed candidate.
- sad_idx  out  IDX_W  candidate index of sad_value.
- min_valid  out  1  at least one candidate has completed since reset/clear.
- min_sad  out  SAD_W  smallest SAD since reset/clear.
- min_idx  out  IDX_W  index of min_sad.
- busy  out  1  partial block or in-flight beat pending.

Behaviour:
- Reset (async, any time): all pipeline registers, accumulator, beat counter and cand_idx go to 0. Outputs: sad_valid=0, sad_value=0, sad_idx=0, min_valid=0, min_sad=all ones, min_idx=0, busy=0.
- Stage 1, at edge E where in_valid=1 and clear=0:
  - Register per-lane |win-frm| and sum the lanes into lane_sum (width PIX_W+clog2(LANES), no overflow possible).
  - Register a last flag = (beat_cnt==BEATS-1).
  - beat_cnt increments, wrapping to 0 after BEATS-1.
- Stage 2, at edge E+1:
  - Not last: acc <= sat(acc + lane_sum).
  - Last: sad_value <= sat(acc + lane_sum), sad_idx <= cand_idx, sad_valid=1 for exactly one cycle, acc <= 0, cand_idx++.
  - Consequence: back-to-back blocks stream with no bubble. Latency from the last beat to sad_valid is 2 edges.
- sat(): clamp to 2^SAD_W-1 on overflow; never wrap.
- Minimum tracker, updated on the same edge as sad_valid:
  - If min_valid=0 or new SAD < min_sad: load min_sad and min_idx, and set min_valid=1.
  - Ties keep the earlier index.
- cand_idx wraps from 2^IDX_W-1 to 0 silently. The minimum tracker is unaffected by the wrap.
- in_valid gaps are allowed anywhere within a block; the pipeline holds its state. A stage-1 bubble produces no accumulation.
- clear=1:
  - Next edge: acc, beat_cnt, stage-1 valid, cand_idx and min_valid go to 0; min_sad goes to all ones; sad_valid=0.
  - A beat presented with clear is dropped (clear wins).
  - A last beat already in stage 1 is discarded and produces no sad_valid.
  - sad_value and sad_idx hold their previous values.
- busy = (beat_cnt != 0) | stage-1 valid.
- win_data and frm_data are ignored when in_valid=0.

Test Plan:
- Defaults; 4 beats with win=0x0A0A0A0A and frm=0x05050505, back-to-back -> sad_valid pulses once, 2 edges after beat 4; sad_value=80, sad_idx=0, min_sad=80, min_idx=0.
- Abs-diff direction: win=0x00FF00FF, frm=0xFF00FF00, 4 beats -> sad_value=4080. Then a second block with win=frm -> sad_value=0, min_sad=0, min_idx=1.
- Streaming: 3 candidates with SADs 50, 30, 30, no gaps between blocks -> three sad_valid pulses 4 cycles apart; final min_sad=30, min_idx=1 (tie keeps the earlier index).
- Gaps plus clear: beats 1-2 of a block, in_valid low for 3 cycles, then clear, then a full block of SAD 12 -> no pulse for the partial block; sad_value=12, sad_idx=0, min_idx=0.
- Saturation: SAD_W=10, one block totalling 4080 -> sad_value=1023.
- Async reset asserted mid-block and mid-pulse -> every output returns to its reset value without a clock edge; a post-reset block starts at cand_idx 0.
